interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Sits between the instruction register and the multicycle control FSM, feeding its Opcode input.
//  Latches external interrupt requests, prioritises them, and takes an interrupt only at an instruction fetch.
//  Taking an interrupt substitutes INT_OPCODE for the fetched opcode and saves the return PC in EPC.
//  Supplies the handler vector to the datapath.
// PARAMETERS
//  NUM_IRQ      4         number of interrupt request lines; line 0 has the highest priority
//  DATA_W       16        datapath width (PC, EPC, vector)
//  OP_W         4         opcode width
//  INT_OPCODE   4'hF      opcode the control FSM decodes as "enter interrupt"
//  VECTOR_BASE  16'h0100  handler address for line 0; vector = VECTOR_BASE + (id << 2)
// PORTS
//  CLK           in   1          system clock; everything is on the rising edge
//  Reset         in   1          synchronous, active-high
//  IRQ           in   NUM_IRQ    asynchronous external request lines; rising-edge triggered
//  IRQMaskWrite  in   1          when 1, load IRQMask from IRQMaskData
//  IRQMaskData   in   NUM_IRQ    new per-line enable mask
//  IntEnSet      in   1          set global enable GIE
//  IntEnClr      in   1          clear GIE
//  IRegWrite     in   1          from control: the instruction register loads on this edge (fetch boundary)
//  IntAck        in   1          from control: interrupt entry sequence is finished (PC <= IntVector)
//  RetI          in   1          from control: return-from-interrupt is executing
//  Opcode_in     in   OP_W       opcode field from the instruction register
//  PC_in         in   DATA_W     current PC value
//  Opcode_out    out  OP_W       opcode presented to the control FSM
//  IntVector     out  DATA_W     handler address for the latched id
//  EPC           out  DATA_W     saved return PC
//  InService     out  1          1 when state != IDLE
//  IntPending    out  1          GIE & |(pending & IRQMask)
//  PendingBits   out  NUM_IRQ    raw sticky pending flags
// BEHAVIOUR
//  Reset: state=IDLE, GIE=0, IRQMask=0, pending=0, id=0, EPC=0, sync flops=0.
//   Each edge-detect "previous" flop resets to 1, so a line held high through reset is not an event.
//   Outputs after reset: Opcode_out=Opcode_in, IntVector=VECTOR_BASE, InService=0, IntPending=0.
//  IRQ path: two-flop synchroniser, then rising-edge detect, which sets pending[i].
//   An edge becomes visible in pending 3 CLK edges after the IRQ transition.
//  Eligible set: elig = pending & IRQMask.
//   Winner = lowest index set in elig. This is a fixed priority encoder.
//  State machine, 2-bit encoding:
//   IDLE -> TAKEN:    on an edge with IRegWrite & GIE & |elig. On that same edge:
//                     id <= winner; EPC <= PC_in; pending[winner] <= 0; GIE <= 0.
//                     PC_in at IRegWrite is the address of the instruction being fetched.
//                     That instruction is discarded and is re-fetched after RetI.
//   TAKEN -> SERVICE: when IntAck=1.
//   SERVICE -> IDLE:  when RetI=1; GIE <= 1 on the same edge.
//   No nesting: IRegWrite is ignored for taking while not in IDLE.
//   RetI outside SERVICE and IntAck outside TAKEN are ignored.
//  Opcode_out (combinational): INT_OPCODE when state==TAKEN, else Opcode_in.
//   Because the take happens on the IR load edge, the control FSM decodes INT_OPCODE on the very next cycle.
//  IntVector = VECTOR_BASE + (id << 2), computed modulo 2^DATA_W.
//   It is held constant from the take until the next take.
//  EPC changes only on a take.
//  Simultaneous events:
//   - New edge on line i in the same cycle pending[i] is cleared by a take: the set wins and pending[i] stays 1.
//   - IntEnSet & IntEnClr together: clear wins.
//   - IntEnSet/IntEnClr on the same edge as a take: the take's GIE<=0 wins; GIE<=1 on RetI wins over IntEnClr.
//   - IRQMaskWrite on the take edge: the winner is chosen with the old mask; the new mask applies next cycle.
//   - Masked pending bits stay set. Unmasking later makes them eligible.
//  Reset mid-operation (TAKEN or SERVICE): return to IDLE with all reset values; pending events are lost.
// STRUCTURE
//  Shared package ctrl_pkg: INT_OPCODE, VECTOR_BASE, state encodings (IDLE=0, TAKEN=1, SERVICE=2).
//   The control FSM imports the same INT_OPCODE.
//  Sub-module irq_sync_edge: one per line (generate loop).
//   Contains the 2-flop synchroniser plus the edge pulse; previous flop resets to 1.
//  Top level holds: pending/mask/GIE registers, priority encoder, state FSM, EPC, vector adder, opcode mux.
// TESTING
//  1. Reset, mask=4'b1111, IntEnSet; pulse IRQ[2]; IRegWrite with PC_in=16'h0040, Opcode_in=4'h8
//     -> next cycle Opcode_out=4'hF, IntVector=16'h0108, EPC=16'h0040, InService=1, pending[2]=0.
//  2. IRQ[1] and IRQ[3] edges in the same cycle, then take
//     -> id=1, IntVector=16'h0104, pending=4'b1000. IntAck, then RetI -> IDLE, GIE=1;
//     next IRegWrite takes line 3, IntVector=16'h010C.
//  3. GIE=0 or IRQMask[0]=0 with pending[0]=1; IRegWrite
//     -> no take, Opcode_out=Opcode_in=4'hE, IntPending=0; after unmask+IntEnSet, next IRegWrite takes line 0.
//  4. In SERVICE, a new IRQ[0] edge plus IRegWrite -> no take, pending[0]=1, EPC unchanged;
//     after RetI, first IRegWrite takes line 0.
//  5. IRQ held high through Reset -> pending stays 0;
//     Reset asserted while in TAKEN -> next cycle IDLE, Opcode_out=Opcode_in, EPC=0, GIE=0.
//  6. IntEnSet & IntEnClr in the same cycle -> GIE=0;
//     IRQ[2] edge coincident with its own take -> pending[2] remains 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: constants shared by the interrupt controller and the multicycle control FSM
package ctrl_pkg;
    localparam logic [3:0]  INT_OPCODE  = 4'hF;
    localparam logic [15:0] VECTOR_BASE = 16'h0100;
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_TAKEN    = 2'd1;
    localparam logic [1:0]  ST_SERVICE  = 2'd2;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser plus rising-edge pulse for one request line
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic rise
);
    logic       meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    logic [1:0] fill_q, fill_d;
    // prev holds 1 until the synchroniser carries real post-reset samples, so a line high through reset is no event
    always_comb begin
        meta_d = irq;
        sync_d = meta_q;
        fill_d = {fill_q[0], 1'b1};
        prev_d = fill_q[1] ? sync_q : 1'b1;
    end
    // register the synchroniser, history and fill tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b1;
            fill_q <= 2'b00;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end
    assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches and prioritises IRQs, substitutes the interrupt opcode at fetch and saves EPC
module interrupt_controller
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int DATA_W  = 16,
    parameter int OP_W    = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               IRQMaskWrite,
    input  logic [NUM_IRQ-1:0] IRQMaskData,
    input  logic               IntEnSet,
    input  logic               IntEnClr,
    input  logic               IRegWrite,
    input  logic               IntAck,
    input  logic               RetI,
    input  logic [OP_W-1:0]    Opcode_in,
    input  logic [DATA_W-1:0]  PC_in,
    output logic [OP_W-1:0]    Opcode_out,
    output logic [DATA_W-1:0]  IntVector,
    output logic [DATA_W-1:0]  EPC,
    output logic               InService,
    output logic               IntPending,
    output logic [NUM_IRQ-1:0] PendingBits
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] rise, elig, win_oh;
    logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, mask_d;
    logic [ID_W-1:0]    winner, id_q, id_d;
    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  epc_q, epc_d;
    logic               gie_q, gie_d, take, ret;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk  (CLK),
            .rst  (Reset),
            .irq  (IRQ[g]),
            .rise (rise[g])
        );
    end

    // fixed-priority pick of the lowest eligible line; scanning downward leaves the lowest index last
    always_comb begin
        elig   = pending_q & mask_q;
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (elig[i]) winner = ID_W'(i);
        win_oh = NUM_IRQ'(1) << winner;
        take   = (state_q == ST_IDLE) && IRegWrite && gie_q && (|elig);
        ret    = (state_q == ST_SERVICE) && RetI;
    end

    // next state; a coincident new edge re-sets the pending bit the take clears
    always_comb begin
        pending_d = (pending_q & ~(take ? win_oh : '0)) | rise;
        mask_d    = IRQMaskWrite ? IRQMaskData : mask_q;
        gie_d     = ret ? 1'b1 : take ? 1'b0 : IntEnClr ? 1'b0 : IntEnSet ? 1'b1 : gie_q;
        state_d   = take ? ST_TAKEN
                  : (state_q == ST_TAKEN && IntAck) ? ST_SERVICE
                  : ret ? ST_IDLE : state_q;
        id_d      = take ? winner : id_q;
        epc_d     = take ? PC_in : epc_q;
    end

    // controller registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            state_q   <= ST_IDLE;
            id_q      <= '0;
            epc_q     <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            state_q   <= state_d;
            id_q      <= id_d;
            epc_q     <= epc_d;
        end
    end

    assign Opcode_out  = (state_q == ST_TAKEN) ? OP_W'(INT_OPCODE) : Opcode_in;
    assign IntVector   = DATA_W'(VECTOR_BASE) + (DATA_W'(id_q) << 2);
    assign EPC         = epc_q;
    assign InService   = state_q != ST_IDLE;
    assign IntPending  = gie_q & (|elig);
    assign PendingBits = pending_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scenarios plus random traffic checked against a behavioural model
module tb_interrupt_controller;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  IRQ = '0;
    logic        IRQMaskWrite = 1'b0;
    logic [3:0]  IRQMaskData = '0;
    logic        IntEnSet = 1'b0, IntEnClr = 1'b0;
    logic        IRegWrite = 1'b0, IntAck = 1'b0, RetI = 1'b0;
    logic [3:0]  Opcode_in = 4'h3;
    logic [15:0] PC_in = '0;
    logic [3:0]  Opcode_out;
    logic [15:0] IntVector, EPC;
    logic        InService, IntPending;
    logic [3:0]  PendingBits;

    int tests = 0;
    int fails = 0;

    interrupt_controller dut (
        .CLK(clk), .Reset(Reset), .IRQ(IRQ), .IRQMaskWrite(IRQMaskWrite), .IRQMaskData(IRQMaskData),
        .IntEnSet(IntEnSet), .IntEnClr(IntEnClr), .IRegWrite(IRegWrite), .IntAck(IntAck), .RetI(RetI),
        .Opcode_in(Opcode_in), .PC_in(PC_in), .Opcode_out(Opcode_out), .IntVector(IntVector), .EPC(EPC),
        .InService(InService), .IntPending(IntPending), .PendingBits(PendingBits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases are 0 idle, 1 entering interrupt, 2 in handler
    int        m_phase = 0, m_id = 0, n = 0;
    bit        m_gie = 0, m_valid = 0;
    bit [3:0]  m_mask = 0, m_pend = 0, h0 = 0, h1 = 0, h2 = 0, h3 = 0;
    bit [15:0] m_epc = 0;

    always @(posedge clk) begin
        bit [3:0] ev, elig;
        bit       take, found;
        int       w;
        if (Reset) begin
            m_phase = 0; m_gie = 0; m_mask = 0; m_pend = 0; m_id = 0; m_epc = 0;
            n = 0; h0 = 0; h1 = 0; h2 = 0; h3 = 0; m_valid = 1;
        end else begin
            n++;
            h3 = h2; h2 = h1; h1 = h0; h0 = IRQ;
            // a request line becomes an event two edges after it is first sampled high, having been sampled low before
            ev = (n >= 4) ? (h2 & ~h3) : 4'b0;
            elig = m_pend & m_mask;
            take = (m_phase == 0) && IRegWrite && m_gie && (elig != 0);
            w = 0; found = 0;
            for (int i = 0; i < 4; i++)
                if (elig[i] && !found) begin w = i; found = 1; end
            if (take) begin m_pend[w] = 0; m_id = w; m_epc = PC_in; end
            m_pend |= ev;
            if (IntEnSet) m_gie = 1;
            if (IntEnClr) m_gie = 0;
            if (take) m_gie = 0;
            if (m_phase == 2 && RetI) m_gie = 1;
            if (IRQMaskWrite) m_mask = IRQMaskData;
            if (take) m_phase = 1;
            else if (m_phase == 1 && IntAck) m_phase = 2;
            else if (m_phase == 2 && RetI) m_phase = 0;
        end
    end

    // compare every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_opcode", Opcode_out, (m_phase == 1) ? 4'hF : Opcode_in);
            chk("m_vector", IntVector, 16'h0100 + 16'(m_id * 4));
            chk("m_epc", EPC, m_epc);
            chk("m_inservice", InService, m_phase != 0);
            chk("m_intpending", IntPending, m_gie && ((m_pend & m_mask) != 0));
            chk("m_pending", PendingBits, m_pend);
        end
    end

    task automatic cyc(input int k = 1);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #2;
            IRegWrite = 0; IntAck = 0; RetI = 0; IntEnSet = 0; IntEnClr = 0; IRQMaskWrite = 0;
        end
    endtask

    initial begin
        cyc(2);
        Reset = 0;
        // 1: reset outputs, then a simple take of line 2
        chk("rst_opcode", Opcode_out, 4'h3);
        chk("rst_vector", IntVector, 16'h0100);
        chk("rst_epc", EPC, 16'h0000);
        chk("rst_inservice", InService, 1'b0);
        chk("rst_intpending", IntPending, 1'b0);
        chk("rst_pending", PendingBits, 4'b0000);
        IRQMaskWrite = 1; IRQMaskData = 4'hF; IntEnSet = 1; cyc();
        IRQ[2] = 1; cyc(3);
        chk("t1_pend", PendingBits, 4'b0100);
        chk("t1_intpending", IntPending, 1'b1);
        IRQ[2] = 0; IRegWrite = 1; PC_in = 16'h0040; Opcode_in = 4'h8; cyc();
        chk("t1_opcode", Opcode_out, 4'hF);
        chk("t1_vector", IntVector, 16'h0108);
        chk("t1_epc", EPC, 16'h0040);
        chk("t1_inservice", InService, 1'b1);
        chk("t1_pend_clr", PendingBits, 4'b0000);
        IntAck = 1; cyc();
        chk("t1_opcode_pass", Opcode_out, 4'h8);
        RetI = 1; cyc();
        chk("t1_idle", InService, 1'b0);
        // 2: two simultaneous requests, line 1 wins, line 3 next
        IRQ[1] = 1; IRQ[3] = 1; cyc(3);
        chk("t2_pend", PendingBits, 4'b1010);
        IRQ = 0; IRegWrite = 1; PC_in = 16'h0050; cyc();
        chk("t2_vector", IntVector, 16'h0104);
        chk("t2_pend_left", PendingBits, 4'b1000);
        IntAck = 1; cyc();
        RetI = 1; cyc();
        chk("t2_gie_back", IntPending, 1'b1);
        IRegWrite = 1; cyc();
        chk("t2_vector3", IntVector, 16'h010C);
        IntAck = 1; cyc();
        RetI = 1; cyc();
        // 3: GIE off, then line 0 masked, then both enabled
        IntEnClr = 1; cyc();
        IRQ[0] = 1; cyc(3);
        IRQ[0] = 0; Opcode_in = 4'hE; IRegWrite = 1; cyc();
        chk("t3_opcode", Opcode_out, 4'hE);
        chk("t3_no_take", InService, 1'b0);
        chk("t3_intpending", IntPending, 1'b0);
        chk("t3_pend", PendingBits, 4'b0001);
        IRQMaskWrite = 1; IRQMaskData = 4'b1110; IntEnSet = 1; cyc();
        IRegWrite = 1; cyc();
        chk("t3_masked", InService, 1'b0);
        chk("t3_masked_ip", IntPending, 1'b0);
        IRQMaskWrite = 1; IRQMaskData = 4'hF; cyc();
        chk("t3_unmasked_ip", IntPending, 1'b1);
        IRegWrite = 1; PC_in = 16'h0060; cyc();
        chk("t3_vector", IntVector, 16'h0100);
        chk("t3_epc", EPC, 16'h0060);
        // 4: no nesting while in service
        IntAck = 1; cyc();
        IRQ[0] = 1; cyc(2);
        IRegWrite = 1; PC_in = 16'h0070; cyc();
        IRQ[0] = 0;
        chk("t4_pend", PendingBits, 4'b0001);
        chk("t4_epc", EPC, 16'h0060);
        chk("t4_inservice", InService, 1'b1);
        RetI = 1; cyc();
        IRegWrite = 1; PC_in = 16'h0080; cyc();
        chk("t4_vector", IntVector, 16'h0100);
        chk("t4_epc2", EPC, 16'h0080);
        IntAck = 1; cyc();
        RetI = 1; cyc();
        // 5: line high through reset, then reset while TAKEN
        IRQ[1] = 1; Reset = 1; cyc(3);
        Reset = 0; cyc(5);
        chk("t5_no_event", PendingBits, 4'b0000);
        IRQ[1] = 0;
        IRQMaskWrite = 1; IRQMaskData = 4'hF; IntEnSet = 1; cyc();
        IRQ[3] = 1; cyc(3);
        IRQ[3] = 0; IRegWrite = 1; PC_in = 16'h0090; cyc();
        chk("t5_taken", InService, 1'b1);
        Reset = 1; cyc();
        Reset = 0;
        chk("t5_rst_inservice", InService, 1'b0);
        chk("t5_rst_opcode", Opcode_out, Opcode_in);
        chk("t5_rst_epc", EPC, 16'h0000);
        // 6: set and clear together, then an edge coinciding with its own take
        IRQMaskWrite = 1; IRQMaskData = 4'hF; IntEnSet = 1; IntEnClr = 1; cyc();
        IRQ[2] = 1; cyc(3);
        IRQ[2] = 0; cyc();
        chk("t6_pend", PendingBits, 4'b0100);
        chk("t6_gie_clr", IntPending, 1'b0);
        IntEnSet = 1; cyc();
        chk("t6_gie_set", IntPending, 1'b1);
        IRQ[2] = 1; cyc(2);
        IRegWrite = 1; PC_in = 16'h00A0; cyc();
        chk("t6_vector", IntVector, 16'h0108);
        chk("t6_pend_kept", PendingBits, 4'b0100);
        IRQ[2] = 0; IntAck = 1; cyc();
        RetI = 1; cyc();
        // random traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            Reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) IRQ[i] = ~IRQ[i];
            IRQMaskWrite = ($urandom_range(0, 15) == 0);
            IRQMaskData = 4'($urandom);
            IntEnSet = ($urandom_range(0, 5) == 0);
            IntEnClr = ($urandom_range(0, 15) == 0);
            IRegWrite = ($urandom_range(0, 2) == 0);
            IntAck = ($urandom_range(0, 3) == 0);
            RetI = ($urandom_range(0, 5) == 0);
            Opcode_in = 4'($urandom);
            PC_in = 16'($urandom);
            @(posedge clk);
            #2;
        end
        Reset = 0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
